// File: rtl/imem_sync_loader_if.sv
// Loader burst handshake and stallable fetch port for imem_sync_loader.
// slave = memory side, master = loader/IF-stage side.
interface imem_sync_loader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_base;
  logic [ADDR_WIDTH:0]   load_len;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  load_err;
  logic [DATA_WIDTH-1:0] load_checksum;
  logic                  mem_ready;
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_valid;

  modport slave (
    input  load_start, load_base, load_len, load_valid, load_data, fetch_en, fetch_addr,
    output load_ready, load_done, load_err, load_checksum, mem_ready, instr, instr_valid
  );

  modport master (
    output load_start, load_base, load_len, load_valid, load_data, fetch_en, fetch_addr,
    input  load_ready, load_done, load_err, load_checksum, mem_ready, instr, instr_valid
  );
endinterface

// File: rtl/imem_sync_loader.sv
// Instruction RAM filled by a word-serial loader FSM; fetch has 1-cycle latency and holds on stall.
// Loader backpressures via load_ready (high only in LOAD); fetch returns NOP_WORD until a load completes.
module imem_sync_loader #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input logic                clk,
  input logic                rst_n,
  imem_sync_loader_if.slave  bus
);
  localparam int                    DEPTH_I  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  load_ready_q;
  logic                  load_done_q;
  logic                  load_err_q;
  logic [DATA_WIDTH-1:0] checksum_q;
  logic                  mem_ready_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  instr_valid_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_I];
  logic                  beat;

  assign beat = (state == LOAD) && bus.load_valid && load_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      remaining    <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      checksum_q   <= '0;
      mem_ready_q  <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_start) begin
            load_err_q  <= 1'b0;
            checksum_q  <= '0;
            mem_ready_q <= 1'b0;
            if (bus.load_len > DEPTH) begin
              load_err_q <= 1'b1;
            end else if (bus.load_len == '0) begin
              load_done_q <= 1'b1;
              state       <= DONE;
            end else begin
              ptr          <= bus.load_base;
              remaining    <= bus.load_len;
              load_ready_q <= 1'b1;
              state        <= LOAD;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            // Pointer wraps modulo DEPTH by its natural width.
            ptr        <= ptr + PTR_ONE;
            remaining  <= remaining - LEN_ONE;
            checksum_q <= checksum_q ^ bus.load_data;
            if (remaining == LEN_ONE) begin
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          mem_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is deliberately not reset; contents are meaningless until a load completes.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[ptr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
    end else if (!mem_ready_q) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
    end else if (bus.fetch_en) begin
      instr_q       <= mem[bus.fetch_addr];
      instr_valid_q <= 1'b1;
    end
  end

  assign bus.load_ready    = load_ready_q;
  assign bus.load_done     = load_done_q;
  assign bus.load_err      = load_err_q;
  assign bus.load_checksum = checksum_q;
  assign bus.mem_ready     = mem_ready_q;
  assign bus.instr         = instr_q;
  assign bus.instr_valid   = instr_valid_q;
endmodule

// File: tb/tb_imem_sync_loader.sv
// Directed bench for imem_sync_loader: stimulus pushes expected fetch/done results,
// a separate monitor pops and compares them when the DUT presents them.
module tb_imem_sync_loader;
  logic clk;
  logic rst_n;

  imem_sync_loader_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  imem_sync_loader #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(32),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] done_q[$];
  logic        chk;
  logic        pend;
  logic [32:0] e;
  logic [31:0] dq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: fetch results appear the cycle after the capture edge; done pulses carry the checksum.
  initial begin
    pend = 1'b0;
    forever begin
      @(posedge clk);
      pend = chk;
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_underflow: got %0h expected none", {bus.instr_valid, bus.instr});
        end else begin
          e = exp_q.pop_front();
          check("fetch", {31'b0, bus.instr_valid, bus.instr}, {31'b0, e});
        end
      end
      if (bus.load_done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load_done: got 1 expected 0");
        end else begin
          check("done_checksum", {32'b0, bus.load_checksum}, {32'b0, done_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input logic [5:0] a, input logic [32:0] exp);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = a;
    exp_q.push_back(exp);
    chk = 1'b1;
    step();
  endtask

  task automatic fetch_end();
    chk          = 1'b0;
    bus.fetch_en = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] base, input logic [6:0] len, input logic [31:0] d[$],
                         input bit gaps, input logic [31:0] exp_cs, input bit push_done,
                         input int stop_after);
    int   idx;
    int   budget;
    logic rdy;
    idx = 0;
    budget = 0;
    if (push_done) done_q.push_back(exp_cs);
    bus.load_start = 1'b1;
    bus.load_base  = base;
    bus.load_len   = len;
    step();
    bus.load_start = 1'b0;
    while (idx < d.size() && idx < stop_after && budget < 200) begin
      bus.load_valid = gaps ? ((budget % 3) != 1) : 1'b1;
      bus.load_data  = d[idx];
      @(negedge clk);
      rdy = bus.load_ready;
      @(posedge clk);
      if (bus.load_valid && rdy) idx++;
      #1;
      budget++;
    end
    bus.load_valid = 1'b0;
    if (idx < d.size() && idx < stop_after) begin
      checks++; errors++;
      $display("FAIL load_timeout: got %0d beats expected %0d", idx, d.size());
    end
    if (stop_after >= d.size()) begin
      step();
      step();
    end
  endtask

  initial begin
    chk            = 1'b0;
    rst_n          = 1'b0;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = '0;
    repeat (3) step();
    check("rst_load_ready", 64'(bus.load_ready), 64'd0);
    check("rst_load_done", 64'(bus.load_done), 64'd0);
    check("rst_load_err", 64'(bus.load_err), 64'd0);
    check("rst_checksum", 64'(bus.load_checksum), 64'd0);
    check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
    check("rst_instr", {31'b0, bus.instr_valid, bus.instr}, 64'd0);
    rst_n = 1'b1;
    step();

    // Fetch before any load returns NOP with instr_valid low.
    for (int i = 0; i < 5; i++) fetch(6'd0, {1'b0, 32'h0});
    fetch_end();
    check("t1_mem_ready", 64'(bus.mem_ready), 64'd0);

    // Basic load with gaps in load_valid.
    dq = '{32'h1, 32'h2, 32'h3, 32'h4};
    do_load(6'd0, 7'd4, dq, 1'b1, 32'h4, 1'b1, 4);
    check("t2_mem_ready", 64'(bus.mem_ready), 64'd1);
    check("t2_load_ready", 64'(bus.load_ready), 64'd0);
    check("t2_checksum", 64'(bus.load_checksum), 64'h4);
    for (int i = 0; i < 4; i++) fetch(6'(i), {1'b1, 32'(i + 1)});
    fetch_end();

    // Address wrap 62,63,0,1.
    dq = '{32'hA, 32'hB, 32'hC, 32'hD};
    do_load(6'd62, 7'd4, dq, 1'b0, 32'h0, 1'b1, 4);
    check("t3_load_err", 64'(bus.load_err), 64'd0);
    fetch(6'd62, {1'b1, 32'hA});
    fetch(6'd63, {1'b1, 32'hB});
    fetch(6'd0,  {1'b1, 32'hC});
    fetch(6'd1,  {1'b1, 32'hD});
    fetch_end();

    // Oversized length is rejected without touching RAM.
    bus.load_start = 1'b1;
    bus.load_len   = 7'd65;
    bus.load_base  = 6'd0;
    step();
    bus.load_start = 1'b0;
    step();
    check("t4_load_err", 64'(bus.load_err), 64'd1);
    check("t4_load_ready", 64'(bus.load_ready), 64'd0);
    check("t4_mem_ready", 64'(bus.mem_ready), 64'd0);
    repeat (2) step();
    check("t4_load_ready_hold", 64'(bus.load_ready), 64'd0);

    // Zero-length load completes immediately.
    dq = {};
    do_load(6'd0, 7'd0, dq, 1'b0, 32'h0, 1'b1, 0);
    check("t4_zero_mem_ready", 64'(bus.mem_ready), 64'd1);
    check("t4_zero_err_cleared", 64'(bus.load_err), 64'd0);
    check("t4_zero_checksum", 64'(bus.load_checksum), 64'd0);
    fetch(6'd62, {1'b1, 32'hA});
    fetch(6'd0,  {1'b1, 32'hC});
    fetch(6'd2,  {1'b1, 32'h3});
    fetch_end();

    // Stall holds output while the address keeps moving.
    fetch(6'd2, {1'b1, 32'h3});
    for (int i = 0; i < 3; i++) begin
      bus.fetch_en   = 1'b0;
      bus.fetch_addr = 6'(5 + i);
      exp_q.push_back({1'b1, 32'h3});
      chk = 1'b1;
      step();
    end
    fetch_end();

    // Reset in the middle of a load.
    dq = '{32'h100, 32'h200, 32'h300, 32'h400};
    do_load(6'd20, 7'd4, dq, 1'b0, 32'h0, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_ready", 64'(bus.mem_ready), 64'd0);
    check("t6_rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("t6_rst_load_ready", 64'(bus.load_ready), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    dq = '{32'h11, 32'h22, 32'h44, 32'h88};
    do_load(6'd20, 7'd4, dq, 1'b1, 32'hFF, 1'b1, 4);
    check("t6_mem_ready", 64'(bus.mem_ready), 64'd1);
    fetch(6'd20, {1'b1, 32'h11});
    fetch(6'd21, {1'b1, 32'h22});
    fetch(6'd22, {1'b1, 32'h44});
    fetch(6'd23, {1'b1, 32'h88});
    fetch_end();

    repeat (3) step();
    check("fetch_queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_queue_drained", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
